// File: rtl/am_envelope_detect.sv
// AM envelope detector: |din| -> windowed mean of DECIM samples -> 8-bit envelope.
// Optional DC-removal output stage enabled by defining AM_ENV_DCBLOCK_EN.
module am_envelope_detect #(
    parameter int DECIM    = 64,
    parameter int DC_SHIFT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] din,
    input  logic               din_valid,
    output logic [7:0]         env,
    output logic               env_valid
);
    localparam int DATA_W = 16;
    localparam int MAG_W  = DATA_W - 1;
    localparam int LOG2D  = $clog2(DECIM);
    localparam int ACC_W  = MAG_W + LOG2D;
    localparam logic [LOG2D-1:0] CNT_LAST = LOG2D'(DECIM - 1);

    if (DECIM < 4 || DECIM > 1024 || (DECIM & (DECIM - 1)) != 0 ||
        DC_SHIFT < 0 || DC_SHIFT > 16) begin : g_bad_param
        $error("am_envelope_detect: DECIM must be a power of two in 4..1024, DC_SHIFT in 0..16");
    end

    // -32768 has no positive 16-bit counterpart, so it saturates to full scale.
    function automatic logic [MAG_W-1:0] abs_sat(input logic signed [DATA_W-1:0] x);
        logic signed [DATA_W-1:0] neg;
        neg = -x;
        if (x == {1'b1, {(DATA_W-1){1'b0}}})
            return {MAG_W{1'b1}};
        else if (x < 0)
            return neg[MAG_W-1:0];
        else
            return x[MAG_W-1:0];
    endfunction

    logic [MAG_W-1:0] mag_p0_q, mag_p0_d;
    logic             vld_p0_q, vld_p0_d;
    logic [ACC_W-1:0] acc_q, acc_d, sum_w;
    logic [LOG2D-1:0] cnt_q, cnt_d;
    logic [7:0]       mean8_p1_q, mean8_p1_d;
    logic             vld_p1_q, vld_p1_d;
    logic [7:0]       env_q, env_d;
    logic             env_vld_q, env_vld_d;

    always_comb begin
        mag_p0_d   = mag_p0_q;
        vld_p0_d   = din_valid;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        mean8_p1_d = mean8_p1_q;
        vld_p1_d   = 1'b0;
        if (din_valid)
            mag_p0_d = abs_sat(din);

        // stage 1 -> stage 2: accumulate; the window's last sample is folded into the mean directly
        sum_w = acc_q + ACC_W'(mag_p0_q);
        if (vld_p0_q) begin
            if (cnt_q == CNT_LAST) begin
                acc_d      = '0;
                cnt_d      = '0;
                mean8_p1_d = sum_w[ACC_W-1 -: 8];
                vld_p1_d   = 1'b1;
            end else begin
                acc_d = sum_w;
                cnt_d = cnt_q + LOG2D'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mag_p0_q   <= '0;
            vld_p0_q   <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            mean8_p1_q <= '0;
            vld_p1_q   <= 1'b0;
        end else begin
            mag_p0_q   <= mag_p0_d;
            vld_p0_q   <= vld_p0_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            mean8_p1_q <= mean8_p1_d;
            vld_p1_q   <= vld_p1_d;
        end
    end

`ifdef AM_ENV_DCBLOCK_EN
    function automatic logic [7:0] clamp_u8(input logic signed [10:0] v);
        if (v < 0)
            return 8'h00;
        else if (v > 11'sd255)
            return 8'hFF;
        else
            return v[7:0];
    endfunction

    // dc_q is signed 9.8 fixed point; its integer part lags one window behind the mean.
    logic [7:0]          mean8_p2_q, mean8_p2_d;
    logic                vld_p2_q, vld_p2_d;
    logic signed [16:0]  dc_q, dc_d;
    logic signed [17:0]  dc_diff;
    logic signed [10:0]  env_wide;

    always_comb begin
        mean8_p2_d = vld_p1_q ? mean8_p1_q : mean8_p2_q;
        vld_p2_d   = vld_p1_q;

        // stage 3 -> stage 4: subtract previous-window DC, re-centre at 128, update DC
        dc_diff  = $signed({2'b00, mean8_p2_q, 8'h00}) - $signed({dc_q[16], dc_q});
        env_wide = $signed({3'b000, mean8_p2_q}) - $signed({{2{dc_q[16]}}, dc_q[16:8]})
                   + 11'sd128;
        dc_d      = dc_q;
        env_d     = env_q;
        env_vld_d = vld_p2_q;
        if (vld_p2_q) begin
            env_d = clamp_u8(env_wide);
            dc_d  = dc_q + 17'(dc_diff >>> DC_SHIFT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mean8_p2_q <= '0;
            vld_p2_q   <= 1'b0;
            dc_q       <= '0;
            env_q      <= '0;
            env_vld_q  <= 1'b0;
        end else begin
            mean8_p2_q <= mean8_p2_d;
            vld_p2_q   <= vld_p2_d;
            dc_q       <= dc_d;
            env_q      <= env_d;
            env_vld_q  <= env_vld_d;
        end
    end
`else
    always_comb begin
        // stage 2 -> output: env holds between pulses
        env_d     = vld_p1_q ? mean8_p1_q : env_q;
        env_vld_d = vld_p1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            env_q     <= '0;
            env_vld_q <= 1'b0;
        end else begin
            env_q     <= env_d;
            env_vld_q <= env_vld_d;
        end
    end
`endif

    assign env       = env_q;
    assign env_valid = env_vld_q;

endmodule

// File: tb/tb_am_envelope_detect.sv
// Directed and random-vs-model bench for am_envelope_detect (DECIM=4, default build).
module tb_am_envelope_detect;
    localparam int DECIM = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] din;
    logic               din_valid;
    logic [7:0]         env;
    logic               env_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    am_envelope_detect #(.DECIM(DECIM), .DC_SHIFT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .env       (env),
        .env_valid (env_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // one rising edge, then settle so outputs are sampled away from the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        din_valid = 1'b1;
        din = 16'sd1000;
        step();
        step();
        rst = 1'b0;
        din_valid = 1'b0;
        din = '0;
    endtask

    // reference model state for the random run
    int         m_sum, m_cnt;
    logic       m_d0_v, m_d1_v, m_out_v;
    logic [7:0] m_d0_e, m_d1_e, m_out_e;

    initial begin
        rst = 1'b1;
        din = '0;
        din_valid = 1'b0;
        #2;

        // reset state, with din_valid high during reset
        do_reset();
        check("reset_env", 32'(env), 32'h00);
        check("reset_vld", 32'(env_valid), 32'h0);

        // continuous 16384: window ends at edge 3, pulses at 5, 9, 13
        for (int t = 0; t < 14; t++) begin
            din = 16'sd16384;
            din_valid = 1'b1;
            step();
            check("A_vld", 32'(env_valid), 32'((t == 5) || (t == 9) || (t == 13)));
            if (env_valid) check("A_env", 32'(env), 32'h80);
        end
        din_valid = 1'b0;
        for (int t = 0; t < 4; t++) begin
            step();
            check("A_hold_vld", 32'(env_valid), 32'h0);
            check("A_hold_env", 32'(env), 32'h80);
        end

        // -32768 saturates to 32767 -> 0xFF
        do_reset();
        for (int t = 0; t < 10; t++) begin
            din = -16'sd32768;
            din_valid = 1'b1;
            step();
            check("B_vld", 32'(env_valid), 32'((t == 5) || (t == 9)));
            if (env_valid) check("B_env", 32'(env), 32'hFF);
        end

        // +-8192 on every other cycle: accepted at 0,2,4,6 -> pulse 8, next 16
        do_reset();
        for (int t = 0; t < 18; t++) begin
            din_valid = (t % 2 == 0);
            din = (t % 4 == 0) ? 16'sd8192 : -16'sd8192;
            step();
            check("C_vld", 32'(env_valid), 32'((t == 8) || (t == 16)));
            if (env_valid) check("C_env", 32'(env), 32'h40);
        end

        // two full-scale samples, reset mid-window, then four of 4096 -> only 0x20
        do_reset();
        for (int t = 0; t < 12; t++) begin
            rst = (t == 2);
            din_valid = (t <= 6);
            din = (t <= 2) ? 16'sd32767 : 16'sd4096;
            step();
            check("D_vld", 32'(env_valid), 32'(t == 8));
            if (env_valid) check("D_env", 32'(env), 32'h20);
        end
        rst = 1'b0;

        // random stimulus against a behavioural window model
        do_reset();
        m_sum = 0; m_cnt = 0;
        m_d0_v = 0; m_d1_v = 0; m_out_v = 0;
        m_d0_e = 0; m_d1_e = 0; m_out_e = 0;
        for (int t = 0; t < 4000; t++) begin
            int v, m;
            rst = ($urandom_range(0, 399) == 0);
            din = 16'($urandom);
            if ($urandom_range(0, 15) == 0) din = -16'sd32768;
            din_valid = ($urandom_range(0, 3) != 0);
            if (rst) begin
                m_sum = 0; m_cnt = 0;
                m_d0_v = 0; m_d1_v = 0; m_out_v = 0;
                m_d0_e = 0; m_d1_e = 0; m_out_e = 0;
            end else begin
                m_out_v = m_d1_v;
                if (m_d1_v) m_out_e = m_d1_e;
                m_d1_v = m_d0_v;
                m_d1_e = m_d0_e;
                m_d0_v = 0;
                if (din_valid) begin
                    v = din;
                    m = (v < 0) ? -v : v;
                    if (m > 32767) m = 32767;
                    m_sum += m;
                    m_cnt++;
                    if (m_cnt == DECIM) begin
                        m_d0_v = 1;
                        m_d0_e = 8'(((m_sum / DECIM) >> 7) & 255);
                        m_sum = 0;
                        m_cnt = 0;
                    end
                end
            end
            step();
            check("R_vld", 32'(env_valid), 32'(m_out_v));
            check("R_env", 32'(env), 32'(m_out_e));
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
